// File: rtl/roulette_pkg.sv
// Shared types and default constants for the roulette LED spinner.
// Build option: SPINNER_BLINK_EN adds the winner-blink default constant.
package roulette_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    SETTLE,
    HOLD
  } state_t;

  localparam int DEF_NUM_LEDS    = 37;
  localparam int DEF_SEL_W       = 3;
  localparam int DEF_NUM_GROUPS  = 6;
  localparam int DEF_BASE_PERIOD = 4;
  localparam int DEF_MAX_PERIOD  = 16;
`ifdef SPINNER_BLINK_EN
  localparam int DEF_BLINK_HALF  = 1 << 24;
`endif

  // Width needed to hold any index 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/roulette_led_map.sv
// Combinational pocket-index to grouped mux-select decoder.
// Each group drives up to 2^SEL_W-1 LEDs; select 0 turns a group off.
module roulette_led_map
  import roulette_pkg::*;
#(
  parameter int  NUM_LEDS   = DEF_NUM_LEDS,
  parameter int  SEL_W      = DEF_SEL_W,
  parameter int  NUM_GROUPS = DEF_NUM_GROUPS,
  localparam int IDX_W      = idx_width(NUM_LEDS)
) (
  input  logic [IDX_W-1:0]            index,
  output logic [NUM_GROUPS*SEL_W-1:0] sel
);

  localparam int PER_GROUP = (1 << SEL_W) - 1;

  // Light exactly one LED in the group owning the index; indices past the ring stay dark.
  always_comb begin
    sel = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (int'(index) < NUM_LEDS &&
          int'(index) >= g * PER_GROUP &&
          int'(index) < (g + 1) * PER_GROUP) begin
        sel[g*SEL_W +: SEL_W] = SEL_W'(int'(index) - g * PER_GROUP + 1);
      end
    end
  end

endmodule

// File: rtl/roulette_spinner.sv
// Roulette LED ring driver: decelerating spin animation that lands on a target pocket.
// Build option: SPINNER_BLINK_EN makes the held winner blink with half-period BLINK_HALF.
module roulette_spinner
  import roulette_pkg::*;
#(
  parameter int  NUM_LEDS    = DEF_NUM_LEDS,
  parameter int  SEL_W       = DEF_SEL_W,
  parameter int  NUM_GROUPS  = DEF_NUM_GROUPS,
  parameter int  BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int  MAX_PERIOD  = DEF_MAX_PERIOD,
`ifdef SPINNER_BLINK_EN
  parameter int  BLINK_HALF  = DEF_BLINK_HALF,
`endif
  localparam int IDX_W       = idx_width(NUM_LEDS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [IDX_W-1:0]            target,
  output logic [NUM_GROUPS*SEL_W-1:0] mux_sel,
  output logic [IDX_W-1:0]            led_number,
  output logic                        busy,
  output logic                        done
);

  localparam int               PER_W    = $clog2(MAX_PERIOD + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [PER_W-1:0] BASE_P   = PER_W'(BASE_PERIOD);
  localparam logic [PER_W-1:0] MAX_P    = PER_W'(MAX_PERIOD);

  state_t                      state, next_state;
  logic [IDX_W-1:0]            pos, next_pos, tgt, next_tgt, pos_inc, disp;
  logic [PER_W-1:0]            period, next_period, cnt, next_cnt;
  logic                        next_done, step, wrap, accept, hold_dark;
  logic [NUM_GROUPS*SEL_W-1:0] map_sel;

  assign accept  = start && ({1'b0, target} < (IDX_W + 1)'(NUM_LEDS));
  assign step    = (cnt == period - 1'b1);
  assign wrap    = (pos == LAST_IDX);
  assign pos_inc = wrap ? '0 : pos + 1'b1;
  assign disp    = (state == IDLE) ? target : pos;
  assign busy    = (state == SPIN) || (state == SETTLE);

  // Spin state and step timing registers; reset puts the ring back at pocket 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      pos    <= '0;
      tgt    <= '0;
      period <= BASE_P;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      state  <= next_state;
      pos    <= next_pos;
      tgt    <= next_tgt;
      period <= next_period;
      cnt    <= next_cnt;
      done   <= next_done;
    end
  end

  // Next-state logic: each revolution doubles the step period until the slowest lap, then settle on target.
  always_comb begin
    next_state  = state;
    next_pos    = pos;
    next_tgt    = tgt;
    next_period = period;
    next_cnt    = cnt;
    next_done   = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          next_tgt    = target;
          next_period = BASE_P;
          next_cnt    = '0;
          next_state  = SPIN;
        end
      end
      SPIN: begin
        if (step) begin
          next_cnt = '0;
          next_pos = pos_inc;
          if (wrap) begin
            if (period < MAX_P) begin
              next_period = period << 1;
            end else if (tgt == '0) begin
              next_state = HOLD;
              next_done  = 1'b1;
            end else begin
              next_state = SETTLE;
            end
          end
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (step) begin
          next_cnt = '0;
          next_pos = pos_inc;
          if (pos_inc == tgt) begin
            next_state = HOLD;
            next_done  = 1'b1;
          end
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  roulette_led_map #(
    .NUM_LEDS  (NUM_LEDS),
    .SEL_W     (SEL_W),
    .NUM_GROUPS(NUM_GROUPS)
  ) u_map (
    .index(disp),
    .sel  (map_sel)
  );

`ifdef SPINNER_BLINK_EN
  localparam int               BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  // Blink phase only advances while holding; elsewhere it rests at the start of an on phase.
  always_ff @(posedge clock) begin
    if (reset || state != HOLD) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign hold_dark = (state == HOLD) && !blink_on;
`else
  assign hold_dark = 1'b0;
`endif

  // Registered display outputs, one clock behind the displayed index.
  always_ff @(posedge clock) begin
    if (reset) begin
      mux_sel    <= '0;
      led_number <= '0;
    end else begin
      mux_sel    <= hold_dark ? '0 : map_sel;
      led_number <= disp;
    end
  end

endmodule

// File: tb/tb_roulette_spinner.sv
// Self-checking bench for roulette_spinner against a step-schedule reference model.
// Build option: SPINNER_BLINK_EN switches the hold expectation to an 8-clock blink.
module tb_roulette_spinner;

  localparam int NUM_LEDS    = 37;
  localparam int SEL_W       = 3;
  localparam int NUM_GROUPS  = 6;
  localparam int BASE_PERIOD = 4;
  localparam int MAX_PERIOD  = 16;
  localparam int IDX_W       = 6;
  localparam int BUS_W       = NUM_GROUPS * SEL_W;
`ifdef SPINNER_BLINK_EN
  localparam int BLINK_HALF  = 8;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [IDX_W-1:0] target;
  logic [BUS_W-1:0] mux_sel;
  logic [IDX_W-1:0] led_number;
  logic             busy;
  logic             done;

  int checks    = 0;
  int failures  = 0;
  int model_pos = 0;
  int step_end[$];

  always #5 clock = ~clock;

  roulette_spinner #(
    .NUM_LEDS   (NUM_LEDS),
    .SEL_W      (SEL_W),
    .NUM_GROUPS (NUM_GROUPS),
    .BASE_PERIOD(BASE_PERIOD),
    .MAX_PERIOD (MAX_PERIOD)
`ifdef SPINNER_BLINK_EN
    , .BLINK_HALF(BLINK_HALF)
`endif
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .target    (target),
    .mux_sel   (mux_sel),
    .led_number(led_number),
    .busy      (busy),
    .done      (done)
  );

  // Group n/7 gets select (n mod 7)+1, every other group 0.
  function automatic logic [BUS_W-1:0] expected_sel(input int n);
    logic [BUS_W-1:0] s;
    int per;
    per = (1 << SEL_W) - 1;
    s = '0;
    s[(n / per) * SEL_W +: SEL_W] = SEL_W'(n % per + 1);
    return s;
  endfunction

  // Step completion times (clocks after the start edge) for a spin from p to t; returns landing time.
  function automatic int build_schedule(input int p, input int t);
    int acc, per, cur;
    acc = 0;
    per = BASE_PERIOD;
    cur = p;
    step_end.delete();
    while (1) begin
      for (int i = cur; i < NUM_LEDS; i++) begin
        acc += per;
        step_end.push_back(acc);
      end
      cur = 0;
      if (per >= MAX_PERIOD) break;
      per *= 2;
    end
    for (int i = 0; i < t; i++) begin
      acc += MAX_PERIOD;
      step_end.push_back(acc);
    end
    return acc;
  endfunction

  // Ring position once k clocks have elapsed after the start edge.
  function automatic int pos_after(input int p, input int k);
    int n;
    n = 0;
    foreach (step_end[i]) if (step_end[i] <= k) n++;
    return (p + n) % NUM_LEDS;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    target = '0;
    repeat (3) @(negedge clock);
    checks += 4;
    if (mux_sel !== '0) begin failures++; $display("[TB] FAIL reset_mux_sel got %h want 0", mux_sel); end
    if (led_number !== '0) begin failures++; $display("[TB] FAIL reset_led_number got %0d want 0", led_number); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    model_pos = 0;
  endtask

  task automatic test_idle_display();
    int t;
    for (int r = 0; r < 5; r++) begin
      t = (r == 0) ? 12 : int'($urandom_range(0, NUM_LEDS - 1));
      target = IDX_W'(t);
      repeat (2) @(negedge clock);
      checks += 3;
      if (led_number !== IDX_W'(t)) begin failures++; $display("[TB] FAIL idle_led_number got %0d want %0d", led_number, t); end
      if (mux_sel !== expected_sel(t)) begin failures++; $display("[TB] FAIL idle_mux_sel got %h want %h", mux_sel, expected_sel(t)); end
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    end
  endtask

  task automatic test_bad_target();
    @(negedge clock);
    target = IDX_W'(40);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checks += 2;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL bad_target_busy cycle %0d got %b want 0", k, busy); end
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL bad_target_done cycle %0d got %b want 0", k, done); end
      @(negedge clock);
    end
    checks++;
    if (led_number !== IDX_W'(40)) begin failures++; $display("[TB] FAIL bad_target_led got %0d want 40", led_number); end
  endtask

  task automatic test_spin(input int t, input bit poke);
    int land, poke_at, exp_pos;
    bit ok;
    ok = 1'b1;
    land = build_schedule(model_pos, t);
    poke_at = poke ? int'($urandom_range(10, land - 10)) : -1;
    @(negedge clock);
    start = 1'b1;
    target = IDX_W'(t);
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k <= land + 1; k++) begin
      if (ok) begin
        checks += 2;
        if (busy !== (k < land)) begin
          failures++; ok = 1'b0;
          $display("[TB] FAIL spin_busy t=%0d cycle %0d got %b want %b", t, k, busy, (k < land));
        end
        if (done !== (k == land)) begin
          failures++; ok = 1'b0;
          $display("[TB] FAIL spin_done t=%0d cycle %0d got %b want %b", t, k, done, (k == land));
        end
        if (k >= 1) begin
          exp_pos = pos_after(model_pos, k - 1);
          checks += 2;
          if (led_number !== IDX_W'(exp_pos)) begin
            failures++; ok = 1'b0;
            $display("[TB] FAIL spin_led t=%0d cycle %0d got %0d want %0d", t, k, led_number, exp_pos);
          end
          if (mux_sel !== expected_sel(exp_pos)) begin
            failures++; ok = 1'b0;
            $display("[TB] FAIL spin_mux t=%0d cycle %0d got %h want %h", t, k, mux_sel, expected_sel(exp_pos));
          end
        end
      end
      if (k == poke_at) begin
        start = 1'b1;
        target = IDX_W'($urandom_range(0, NUM_LEDS - 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    model_pos = t;
  endtask

  task automatic test_hold(input int t);
    bit on;
    logic [BUS_W-1:0] exp_sel;
    target = IDX_W'($urandom_range(0, NUM_LEDS - 1));
    for (int j = 2; j < 34; j++) begin
`ifdef SPINNER_BLINK_EN
      on = (((j - 1) / BLINK_HALF) % 2) == 0;
`else
      on = 1'b1;
`endif
      exp_sel = on ? expected_sel(t) : '0;
      checks += 3;
      if (mux_sel !== exp_sel) begin failures++; $display("[TB] FAIL hold_mux t=%0d cycle %0d got %h want %h", t, j, mux_sel, exp_sel); end
      if (led_number !== IDX_W'(t)) begin failures++; $display("[TB] FAIL hold_led t=%0d cycle %0d got %0d want %0d", t, j, led_number, t); end
      if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL hold_flags cycle %0d got busy=%b done=%b want 0 0", j, busy, done); end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_spin();
    @(negedge clock);
    start = 1'b1;
    target = IDX_W'(9);
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      checks++;
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL midspin_done cycle %0d got %b want 0", k, done); end
      @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    checks += 4;
    if (mux_sel !== '0) begin failures++; $display("[TB] FAIL midspin_reset_mux got %h want 0", mux_sel); end
    if (led_number !== '0) begin failures++; $display("[TB] FAIL midspin_reset_led got %0d want 0", led_number); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midspin_reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL midspin_reset_done got %b want 0", done); end
    reset = 1'b0;
    model_pos = 0;
  endtask

  initial begin
    int t;
    test_reset();
    test_idle_display();
    test_bad_target();
    test_spin(5, 1'b0);
    test_hold(5);
    test_spin(0, 1'b1);
    test_hold(0);
    test_spin(0, 1'b0);
    test_hold(0);
    for (int r = 0; r < 3; r++) begin
      t = int'($urandom_range(0, NUM_LEDS - 1));
      test_spin(t, 1'b1);
      test_hold(t);
    end
    test_reset_mid_spin();
    test_idle_display();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
